// File: rtl/reshape_word_packer.sv
// reshape_word_packer: packs a byte write stream into 32-bit little-endian words
// with byte enables. Completed words go through a small first-word-fall-through
// FIFO; the block also counts frame bytes and flags frame completion and dropped pushes.
module reshape_word_packer #(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned FRAME_BYTES = 76800
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_en,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [7:0]        in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-3:0] out_addr,
  output logic [31:0]       out_data,
  output logic [3:0]        out_be,
  output logic              frame_done,
  output logic              overflow,
  output logic [ADDR_W-1:0] byte_cnt
);

  localparam int unsigned WA_W  = ADDR_W - 2;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [WA_W-1:0] addr;
    logic [31:0]     data;
    logic [3:0]      be;
  } word_t;

  logic              cap_en_q;
  logic [ADDR_W-1:0] cap_addr_q;
  logic [1:0]        ev_lane;
  word_t             fresh;

  word_t             pk_q, pk_n;
  word_t             push_w0, push_w1;
  logic [1:0]        n_req;
  logic [ADDR_W-1:0] cnt_q, cnt_n;
  logic              frame_end;

  word_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_q, rd_n, wr_q, wr_n, wr_nxt1;
  logic [CNT_W-1:0]  fcnt_q, fcnt_n, free;
  logic [1:0]        n_acc;
  logic              pop, drop;
  logic              valid_q;
  word_t             head_q, head_n;

  logic              drain_q, drain_set, fire;
  logic              frame_done_q, overflow_q;

  // Capture strobe and address; the data byte arrives one cycle later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap_en_q   <= 1'b0;
      cap_addr_q <= '0;
    end else begin
      cap_en_q   <= in_en;
      cap_addr_q <= in_addr;
    end
  end

  // Single-byte word built from the current byte event.
  always_comb begin
    ev_lane    = cap_addr_q[1:0];
    fresh      = '0;
    fresh.addr = cap_addr_q[ADDR_W-1:2];
    fresh.data = 32'(in_data) << {ev_lane, 3'b000};
    fresh.be   = 4'b0001 << ev_lane;
  end

  // Packer merge/restart rules, up to two pushes per event (old word, then new).
  always_comb begin
    pk_n      = pk_q;
    push_w0   = '0;
    push_w1   = '0;
    n_req     = 2'd0;
    cnt_n     = cnt_q;
    frame_end = 1'b0;
    if (cap_en_q) begin
      frame_end = (cnt_q == ADDR_W'(FRAME_BYTES - 1));
      cnt_n     = frame_end ? '0 : cnt_q + ADDR_W'(1);
      if (pk_q.be == 4'h0) begin
        pk_n = fresh;
      end else if ((pk_q.addr == fresh.addr) && !pk_q.be[ev_lane]) begin
        pk_n.data = pk_q.data | fresh.data;
        pk_n.be   = pk_q.be | fresh.be;
      end else begin
        push_w0 = pk_q;
        n_req   = 2'd1;
        pk_n    = fresh;
      end
      if ((pk_n.be == 4'hF) || frame_end) begin
        if (n_req == 2'd0) push_w0 = pk_n;
        else               push_w1 = pk_n;
        n_req = n_req + 2'd1;
        pk_n  = '0;
      end
    end
  end

  // FIFO bookkeeping: accept pushes into free slots, bypass the next head.
  always_comb begin
    pop     = valid_q & out_ready;
    free    = CNT_W'(FIFO_DEPTH) - fcnt_q + CNT_W'(pop);
    n_acc   = (CNT_W'(n_req) <= free) ? n_req : 2'(free);
    drop    = (n_acc != n_req);
    rd_n    = rd_q + PTR_W'(pop);
    wr_n    = wr_q + PTR_W'(n_acc);
    wr_nxt1 = wr_q + PTR_W'(1);
    fcnt_n  = fcnt_q - CNT_W'(pop) + CNT_W'(n_acc);
    head_n  = mem[rd_n];
    if (fcnt_n == '0) begin
      head_n = '0;
    end else if ((n_acc != 2'd0) && (wr_q == rd_n)) begin
      head_n = push_w0;
    end else if ((n_acc == 2'd2) && (wr_nxt1 == rd_n)) begin
      head_n = push_w1;
    end
  end

  // Frame completion: wait until the FIFO and packer are both empty.
  always_comb begin
    drain_set = drain_q | frame_end;
    fire      = drain_set && (fcnt_n == '0) && (pk_n.be == 4'h0);
  end

  // FIFO storage, written only into free slots.
  always_ff @(posedge clk) begin
    if (n_acc != 2'd0) mem[wr_q]    <= push_w0;
    if (n_acc == 2'd2) mem[wr_nxt1] <= push_w1;
  end

  // Packer, counters, FIFO pointers, registered head and status flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pk_q         <= '0;
      cnt_q        <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
      fcnt_q       <= '0;
      valid_q      <= 1'b0;
      head_q       <= '0;
      drain_q      <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      pk_q         <= pk_n;
      cnt_q        <= cnt_n;
      rd_q         <= rd_n;
      wr_q         <= wr_n;
      fcnt_q       <= fcnt_n;
      valid_q      <= (fcnt_n != '0);
      head_q       <= head_n;
      drain_q      <= drain_set & ~fire;
      frame_done_q <= fire;
      overflow_q   <= overflow_q | drop;
    end
  end

  assign out_valid  = valid_q;
  assign out_addr   = head_q.addr;
  assign out_data   = head_q.data;
  assign out_be     = head_q.be;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign byte_cnt   = cnt_q;

endmodule

// File: tb/tb_reshape_word_packer.sv
// Bench for reshape_word_packer: directed table, corner sequences and random
// traffic compared against a transaction-level reference model.
module tb_reshape_word_packer;

  localparam int unsigned ADDR_W  = 20;
  localparam int unsigned WA_W    = ADDR_W - 2;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned FRAME_A = 6;
  localparam int unsigned FRAME_B = 1000;

  logic              clk = 1'b0;
  logic              rstn;
  logic              in_en;
  logic [ADDR_W-1:0] in_addr;
  logic [7:0]        in_data;
  logic              out_ready;

  logic              a_valid, b_valid, a_fd, b_fd, a_ovf, b_ovf;
  logic [WA_W-1:0]   a_addr, b_addr;
  logic [31:0]       a_data, b_data;
  logic [3:0]        a_be, b_be;
  logic [ADDR_W-1:0] a_cnt, b_cnt;

  logic              d_valid, d_fd, d_ovf;
  logic [WA_W-1:0]   d_addr;
  logic [31:0]       d_data;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_cnt;
  bit                sel;

  always #5 clk = ~clk;

  reshape_word_packer #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .FRAME_BYTES(FRAME_A)) u_dut_a (
    .clk(clk), .rstn(rstn), .in_en(in_en), .in_addr(in_addr), .in_data(in_data),
    .out_valid(a_valid), .out_ready(out_ready), .out_addr(a_addr), .out_data(a_data),
    .out_be(a_be), .frame_done(a_fd), .overflow(a_ovf), .byte_cnt(a_cnt)
  );

  reshape_word_packer #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .FRAME_BYTES(FRAME_B)) u_dut_b (
    .clk(clk), .rstn(rstn), .in_en(in_en), .in_addr(in_addr), .in_data(in_data),
    .out_valid(b_valid), .out_ready(out_ready), .out_addr(b_addr), .out_data(b_data),
    .out_be(b_be), .frame_done(b_fd), .overflow(b_ovf), .byte_cnt(b_cnt)
  );

  assign d_valid = sel ? b_valid : a_valid;
  assign d_addr  = sel ? b_addr  : a_addr;
  assign d_data  = sel ? b_data  : a_data;
  assign d_be    = sel ? b_be    : a_be;
  assign d_fd    = sel ? b_fd    : a_fd;
  assign d_ovf   = sel ? b_ovf   : a_ovf;
  assign d_cnt   = sel ? b_cnt   : a_cnt;

  typedef struct packed {
    logic [WA_W-1:0] addr;
    logic [31:0]     data;
    logic [3:0]      be;
  } mword_t;

  // Reference model state: word queue, packer as lane bytes, counters.
  mword_t     q[$];
  bit         m_cap_en;
  int         m_cap_addr;
  int         m_pw;
  logic [7:0] m_lane [4];
  logic [3:0] m_pbe;
  int         m_cnt;
  int         m_frame;
  bit         m_drain, m_fd, m_ovf;

  int         checks;
  int         errors;
  logic [7:0] nxt_d;

  function automatic void ck(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] dfun(int a);
    return 8'(a * 5 + 3);
  endfunction

  function automatic logic [31:0] dword(int a0);
    return {dfun(a0 + 3), dfun(a0 + 2), dfun(a0 + 1), dfun(a0)};
  endfunction

  function automatic mword_t m_word();
    return {WA_W'(m_pw), m_lane[3], m_lane[2], m_lane[1], m_lane[0], m_pbe};
  endfunction

  task automatic model_reset();
    q.delete();
    m_cap_en = 1'b0; m_cap_addr = 0; m_pw = 0; m_pbe = 4'h0; m_cnt = 0;
    m_drain = 1'b0; m_fd = 1'b0; m_ovf = 1'b0;
    for (int j = 0; j < 4; j++) m_lane[j] = 8'h00;
  endtask

  // One clock edge of the reference model, from the byte-event rules.
  task automatic model_edge();
    mword_t pend[$];
    bit     pop;
    int     wa, ln;
    pop = (q.size() > 0) && out_ready;
    if (m_cap_en) begin
      wa = m_cap_addr / 4;
      ln = m_cap_addr % 4;
      m_cnt++;
      if (m_pbe != 4'h0 && (wa != m_pw || m_pbe[ln])) begin
        pend.push_back(m_word());
        m_pbe = 4'h0;
      end
      if (m_pbe == 4'h0) begin
        m_pw = wa;
        for (int j = 0; j < 4; j++) m_lane[j] = 8'h00;
      end
      m_lane[ln] = in_data;
      m_pbe[ln]  = 1'b1;
      if (m_pbe == 4'hF || m_cnt == m_frame) begin
        pend.push_back(m_word());
        m_pbe = 4'h0;
      end
      if (m_cnt == m_frame) begin
        m_cnt   = 0;
        m_drain = 1'b1;
      end
    end
    if (pop) void'(q.pop_front());
    foreach (pend[i]) begin
      if (q.size() < int'(DEPTH)) q.push_back(pend[i]);
      else m_ovf = 1'b1;
    end
    m_fd = m_drain && (q.size() == 0) && (m_pbe == 4'h0);
    if (m_fd) m_drain = 1'b0;
    m_cap_en   = in_en;
    m_cap_addr = int'(in_addr);
  endtask

  task automatic model_check();
    ck("valid", 64'(d_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      ck("head_addr", 64'(d_addr), 64'(q[0].addr));
      ck("head_data", 64'(d_data), 64'(q[0].data));
      ck("head_be",   64'(d_be),   64'(q[0].be));
    end
    ck("overflow",   64'(d_ovf), 64'(m_ovf));
    ck("byte_cnt",   64'(d_cnt), 64'(m_cnt));
    ck("frame_done", 64'(d_fd),  64'(m_fd));
  endtask

  task automatic step(input bit en, input logic [ADDR_W-1:0] a, input logic [7:0] d, input bit rdy);
    in_en = en; in_addr = a; in_data = d; out_ready = rdy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_check();
  endtask

  task automatic send(input int a, input bit rdy, input bit rnd);
    step(1'b1, ADDR_W'(a), nxt_d, rdy);
    nxt_d = rnd ? 8'($urandom) : dfun(a);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, '0, nxt_d, rdy);
    nxt_d = 8'hEE;
  endtask

  task automatic do_reset(input bit s);
    in_en = 1'b0; in_addr = '0; in_data = '0; out_ready = 1'b0;
    rstn = 1'b0;
    sel = s;
    m_frame = s ? int'(FRAME_B) : int'(FRAME_A);
    model_reset();
    nxt_d = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  typedef struct {
    bit              rst;
    bit              en;
    logic [ADDR_W-1:0] addr;
    logic [7:0]      data;
    bit              rdy;
    bit              ev;
    logic [WA_W-1:0] ea;
    logic [31:0]     ed;
    logic [3:0]      eb;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int la;
    checks = 0;
    errors = 0;
    rstn = 1'b0;
    sel = 1'b0;

    // Consecutive bytes, then non-consecutive bytes after a reset.
    tbl[0]  = '{0, 1, 20'd0, 8'h00, 1, 0, 18'd0, 32'h0,         4'h0};
    tbl[1]  = '{0, 1, 20'd1, 8'h11, 1, 0, 18'd0, 32'h0,         4'h0};
    tbl[2]  = '{0, 1, 20'd2, 8'h22, 1, 0, 18'd0, 32'h0,         4'h0};
    tbl[3]  = '{0, 1, 20'd3, 8'h33, 1, 0, 18'd0, 32'h0,         4'h0};
    tbl[4]  = '{0, 0, 20'd0, 8'h44, 1, 1, 18'd0, 32'h44332211,  4'hF};
    tbl[5]  = '{0, 0, 20'd0, 8'h00, 1, 0, 18'd0, 32'h0,         4'h0};
    tbl[6]  = '{1, 0, 20'd0, 8'h00, 0, 0, 18'd0, 32'h0,         4'h0};
    tbl[7]  = '{0, 1, 20'd5, 8'h00, 0, 0, 18'd0, 32'h0,         4'h0};
    tbl[8]  = '{0, 1, 20'd9, 8'hAA, 0, 0, 18'd0, 32'h0,         4'h0};
    tbl[9]  = '{0, 0, 20'd0, 8'hBB, 0, 1, 18'd1, 32'h0000AA00,  4'b0010};
    tbl[10] = '{0, 0, 20'd0, 8'h00, 0, 1, 18'd1, 32'h0000AA00,  4'b0010};
    tbl[11] = '{0, 0, 20'd0, 8'h00, 1, 0, 18'd0, 32'h0,         4'h0};

    do_reset(1'b0);
    ck("rst_valid", 64'(d_valid), 64'd0);
    ck("rst_addr",  64'(d_addr),  64'd0);
    ck("rst_data",  64'(d_data),  64'd0);
    ck("rst_be",    64'(d_be),    64'd0);
    ck("rst_fd",    64'(d_fd),    64'd0);
    ck("rst_ovf",   64'(d_ovf),   64'd0);
    ck("rst_cnt",   64'(d_cnt),   64'd0);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].rst) begin
        do_reset(1'b0);
      end else begin
        step(tbl[i].en, tbl[i].addr, tbl[i].data, tbl[i].rdy);
        ck($sformatf("tbl%0d_valid", i), 64'(d_valid), 64'(tbl[i].ev));
        if (tbl[i].ev) begin
          ck($sformatf("tbl%0d_addr", i), 64'(d_addr), 64'(tbl[i].ea));
          ck($sformatf("tbl%0d_data", i), 64'(d_data), 64'(tbl[i].ed));
          ck($sformatf("tbl%0d_be", i),   64'(d_be),   64'(tbl[i].eb));
        end
      end
    end

    // Backpressure: nine full words into an eight-entry FIFO.
    do_reset(1'b1);
    for (int a = 0; a < 35; a++) send(a, 1'b0, 1'b0);
    ck("ovf_before", 64'(d_ovf), 64'd0);
    send(35, 1'b0, 1'b0);
    idle(1'b0);
    ck("ovf_after", 64'(d_ovf), 64'd1);
    for (int k = 0; k < 8; k++) begin
      ck("bp_valid", 64'(d_valid), 64'd1);
      ck("bp_addr",  64'(d_addr),  64'(k));
      ck("bp_data",  64'(d_data),  64'(dword(4 * k)));
      ck("bp_be",    64'(d_be),    64'hF);
      idle(1'b1);
    end
    ck("bp_empty", 64'(d_valid), 64'd0);
    ck("bp_ovf_sticky", 64'(d_ovf), 64'd1);

    // Push and pop in the same cycle while the FIFO is full.
    do_reset(1'b1);
    for (int a = 0; a < 36; a++) send(a, 1'b0, 1'b0);
    idle(1'b1);
    ck("pp_ovf", 64'(d_ovf), 64'd0);
    n = 0;
    for (int g = 0; g < 20 && d_valid; g++) begin
      n++;
      idle(1'b1);
    end
    ck("pp_occupancy", 64'(n), 64'd8);

    // Frame end with a partial last word.
    do_reset(1'b0);
    for (int a = 0; a < 6; a++) send(a, 1'b0, 1'b0);
    idle(1'b0);
    ck("fe_cnt",   64'(d_cnt),  64'd0);
    ck("fe_fd0",   64'(d_fd),   64'd0);
    ck("fe_addr0", 64'(d_addr), 64'd0);
    ck("fe_be0",   64'(d_be),   64'hF);
    ck("fe_data0", 64'(d_data), 64'(dword(0)));
    idle(1'b1);
    ck("fe_addr1", 64'(d_addr), 64'd1);
    ck("fe_be1",   64'(d_be),   64'b0011);
    ck("fe_data1", 64'(d_data), 64'({16'h0, dfun(5), dfun(4)}));
    ck("fe_fd1",   64'(d_fd),   64'd0);
    n = 0;
    for (int g = 0; g < 6; g++) begin
      idle(1'b1);
      if (d_fd) n++;
    end
    ck("fe_pulses", 64'(n), 64'd1);

    // Asynchronous reset with a partial word, three queued words and a capture in flight.
    do_reset(1'b1);
    for (int a = 0; a < 14; a++) send(a, 1'b0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    ck("arst_valid", 64'(d_valid), 64'd0);
    ck("arst_addr",  64'(d_addr),  64'd0);
    ck("arst_data",  64'(d_data),  64'd0);
    ck("arst_be",    64'(d_be),    64'd0);
    ck("arst_fd",    64'(d_fd),    64'd0);
    ck("arst_ovf",   64'(d_ovf),   64'd0);
    ck("arst_cnt",   64'(d_cnt),   64'd0);
    #1 rstn = 1'b1;
    model_reset();
    step(1'b0, '0, dfun(13), 1'b0);
    for (int g = 0; g < 3; g++) begin
      idle(1'b0);
      ck("arst_stale", 64'(d_valid), 64'd0);
    end
    ck("arst_cnt2", 64'(d_cnt), 64'd0);
    for (int a = 100; a < 104; a++) send(a, 1'b0, 1'b0);
    idle(1'b0);
    ck("arst_new_addr", 64'(d_addr), 64'd25);
    ck("arst_new_data", 64'(d_data), 64'(dword(100)));
    ck("arst_new_be",   64'(d_be),   64'hF);
    idle(1'b1);

    // Random traffic on both frame sizes.
    for (int s = 0; s < 2; s++) begin
      do_reset(s[0]);
      la = 0;
      for (int c = 0; c < 1500; c++) begin
        if ($urandom_range(0, 3) != 0) begin
          la = ($urandom_range(0, 1) != 0) ? (la + 1) % 64 : int'($urandom_range(0, 31));
          send(la, $urandom_range(0, 2) != 0, 1'b1);
        end else begin
          idle($urandom_range(0, 2) != 0);
        end
      end
      for (int c = 0; c < 20; c++) idle(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reshape_word_packer.md
# reshape_word_packer

Downstream stage of the flow reshaper. Consumes the reshaped byte write stream (enable + byte address, with the data byte following one cycle later) and packs bytes into 32-bit little-endian words with byte enables. Completed words are buffered in a small FIFO and presented on a valid/ready port toward the frame-store writer. The block also counts frame bytes and flags frame completion and FIFO overflow, because the upstream stream cannot be stalled.

## Interface
- `ADDR_W`, 20, byte address width of the input stream.
- `FIFO_DEPTH`, 8, number of word entries in the output FIFO; must be a power of 2, ≥ 2.
- `FRAME_BYTES`, 76800, number of byte events per frame.

- `clk` input 1: single clock, all logic on rising edge.
- `rstn` input 1: asynchronous active-low reset.
- `in_en` input 1: byte write strobe from the reshaper.
- `in_addr` input `ADDR_W`: byte address, valid while `in_en`=1.
- `in_data` input 8: data byte, valid exactly one cycle after the `in_en` cycle.
- `out_valid` output 1: FIFO head is a valid word.
- `out_ready` input 1: consumer accepts the head word.
- `out_addr` output `ADDR_W-2`: word address, equal to byte address[ADDR_W-1:2].
- `out_data` output 32: packed word; lane k = bits [8k+7:8k].
- `out_be` output 4: byte enables, one bit per lane.
- `frame_done` output 1: one-cycle pulse at frame completion.
- `overflow` output 1: sticky flag, set when a push is dropped.
- `byte_cnt` output `ADDR_W`: byte events counted in the current frame.

## Operation
- **Capture:** `in_en` and `in_addr` are registered. In the next cycle, the registered address is paired with `in_data` to form one byte event (A, D). Byte events can occur every cycle.
- **Packer state:** word address W, 32-bit data register, and 4-bit `be`. The packer is empty when `be`=0. Lane L = A[1:0].
- **Byte event, packer empty:**
  - W ← A[ADDR_W-1:2].
  - Lane L ← D.
  - `be` ← onehot(L).
- **Byte event, A[ADDR_W-1:2]==W and `be`[L]==0:** merge D into lane L and set `be`[L].
- **Byte event, different word or lane already set:**
  - Push the current (partial) word.
  - Restart the packer with the new byte alone.
  - A duplicate lane never overwrites a lane that is already held.
- **Full word:** when `be` becomes 4'hF after a merge, the word is pushed in that same cycle and the packer becomes empty.
- **Unused lanes:** lanes with `be`=0 carry 8'h00 in `out_data`.
- **Frame end:**
  - `byte_cnt` increments on every byte event.
  - On the event that makes the count reach `FRAME_BYTES`, the packer merges the byte and then pushes whatever it holds, partial or full.
  - `byte_cnt` then returns to 0.
  - A "drain pending" flag is set.
- **frame_done:** pulses for 1 cycle in the first cycle where drain pending=1, the FIFO is empty and the packer is empty. Drain pending is cleared in that same cycle.
- **FIFO:** first-word-fall-through. Pop occurs on `out_valid` & `out_ready`.
  - Push when full with no pop in the same cycle: the word is dropped and `overflow` ← 1 until reset.
  - Push when full with a pop in the same cycle: the word is accepted.
  - Push and pop in the same cycle when the FIFO is empty is not possible, because the pushed word appears one cycle later.
- **Head stability:** `out_addr`, `out_data` and `out_be` hold stable while `out_valid`=1 and `out_ready`=0.
- **Reset:** asynchronous. Clears the capture register, packer, FIFO pointers, `byte_cnt`, drain pending and `overflow`. An in-flight `in_data` after reset release is ignored, since its capture was cleared.

## Timing
- **Reset values:** `out_valid`=0, `out_addr`=0, `out_data`=0, `out_be`=0, `frame_done`=0, `overflow`=0, `byte_cnt`=0.
- **Input pairing:** `in_en` in cycle t pairs with `in_data` in t+1. The byte event is applied at the end of t+1.
- **Word latency:** a word pushed at the end of t+1 into an empty FIFO gives `out_valid`=1 in cycle t+2.
- **Byte count:** `byte_cnt` reflects the event of cycle t+1 from cycle t+2.
- **Overflow:** `overflow` rises the cycle after the dropped push.
- **Throughput:** 1 byte event per cycle and 1 word pop per cycle, with no bubbles.

## Test plan
- **Consecutive bytes:** bytes at addr 0,1,2,3 with data 11,22,33,44 on consecutive cycles → one word with `out_addr`=0, `out_data`=32'h44332211, `out_be`=4'hF; `out_valid` high 2 cycles after the last `in_en`.
- **Non-consecutive bytes:** byte addr 5 with data AA, then addr 9 with data BB → first word `out_addr`=1, `out_data`=32'h0000AA00, `out_be`=4'b0010, pushed on the second event. The second byte stays in the packer.
- **Backpressure and overflow:** `out_ready`=0 and 9 full words streamed → 8 words held, `overflow`=1 after the 9th. Releasing `out_ready` drains exactly words 1–8 in order, unchanged.
- **Frame end (`FRAME_BYTES`=6):** addresses 0–5 → words (0, be F) and (1, be 4'b0011). `frame_done` pulses once after both are popped, and `byte_cnt` returns to 0.
- **Push and pop when full:** FIFO full with `out_ready`=1 while a new word is pushed → no overflow, and occupancy stays at 8.
- **Reset mid-frame:** assert `rstn`=0 with a partial word and 3 FIFO entries present → all outputs return to reset values asynchronously, and no stale word appears after release.
